// File: rtl/regfile_sb.sv
// regfile_sb: MIPS GPR file with two registered read ports, one write port, r0 hardwired to zero and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and a cleared busy bit) to the read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              readBusy1,
    output logic              readBusy2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveReg,
    input  logic              flush,
    output logic              allClear
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [NREG];
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_wr_en;
    logic              w_rsv_en;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;
    logic              w_rd_busy1;
    logic              w_rd_busy2;

    assign w_wr_en  = regWrite && (writeReg != '0);
    assign w_rsv_en = reserveEn && (reserveReg != '0);

    // Reserve is applied after release so a same-cycle write+reserve leaves the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wr_en)  w_busy_nxt[writeReg]   = 1'b0;
            if (w_rsv_en) w_busy_nxt[reserveReg] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_rd_data1 = r_mem[readReg1];
        w_rd_data2 = r_mem[readReg2];
        w_rd_busy1 = r_busy[readReg1];
        w_rd_busy2 = r_busy[readReg2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (readReg1 == writeReg)) begin
            w_rd_data1 = writeData;
            w_rd_busy1 = 1'b0;
        end
        if (w_wr_en && (readReg2 == writeReg)) begin
            w_rd_data2 = writeData;
            w_rd_busy2 = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) r_mem[i] <= '0;
            r_busy    <= '0;
            readData1 <= '0;
            readData2 <= '0;
            readBusy1 <= 1'b0;
            readBusy2 <= 1'b0;
            allClear  <= 1'b1;
        end else begin
            if (w_wr_en) r_mem[writeReg] <= writeData;
            r_busy    <= w_busy_nxt;
            readData1 <= w_rd_data1;
            readData2 <= w_rd_data2;
            readBusy1 <= w_rd_busy1;
            readBusy2 <= w_rd_busy2;
            allClear  <= (w_busy_nxt == '0);
        end
    end
endmodule
